// File: rtl/request_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module  : request_arbiter_pkg
// Brief   : Shared constants and FSM state type for the request arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package request_arbiter_pkg;

    localparam int DEFAULT_REQ_NUMBER = 8;
    localparam int DEFAULT_REQ_WIDTH  = 32;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/request_mux.sv
//------------------------------------------------------------------------------
// Module  : request_mux
// Brief   : Selects one requester payload by index.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module request_mux
    import request_arbiter_pkg::*;
#(
    parameter int REQ_NUMBER = DEFAULT_REQ_NUMBER,
    parameter int REQ_WIDTH  = DEFAULT_REQ_WIDTH
) (
    input  logic [REQ_WIDTH-1:0]          data [REQ_NUMBER],
    input  logic [$clog2(REQ_NUMBER)-1:0] select,
    output logic [REQ_WIDTH-1:0]          selected
);

    localparam int ID_WIDTH = $clog2(REQ_NUMBER);

    // Compare-based select keeps non-power-of-two counts free of out-of-range reads.
    always_comb begin
        selected = '0;
        for (int i = 0; i < REQ_NUMBER; i++) begin
            if (select == ID_WIDTH'(i)) begin
                selected = data[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/request_arbiter.sv
//------------------------------------------------------------------------------
// Module  : request_arbiter
// Brief   : Round-robin arbiter feeding a one-entry registered output stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module request_arbiter
    import request_arbiter_pkg::*;
#(
    parameter int REQ_NUMBER = DEFAULT_REQ_NUMBER,
    parameter int REQ_WIDTH  = DEFAULT_REQ_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUMBER-1:0]         req_valid,
    input  logic [REQ_WIDTH-1:0]          req_data [REQ_NUMBER],
    output logic [REQ_NUMBER-1:0]         req_ready,
    output logic                          out_valid,
    output logic [REQ_WIDTH-1:0]          out_data,
    output logic [$clog2(REQ_NUMBER)-1:0] out_id,
    input  logic                          out_ready
);

    localparam int ID_WIDTH = $clog2(REQ_NUMBER);

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic [REQ_WIDTH-1:0]  r_out_data;
    logic [ID_WIDTH-1:0]   w_winner;
    logic [REQ_WIDTH-1:0]  w_mux_data;
    logic                  w_any_valid;
    logic                  w_accept_en;
    logic                  w_accept;

    // First valid index strictly after the last grant, wrapping around.
    function automatic logic [ID_WIDTH-1:0] rr_winner(
        input logic [REQ_NUMBER-1:0] valid,
        input logic [ID_WIDTH-1:0]   last
    );
        logic [ID_WIDTH-1:0] win;
        logic                found;
        int                  idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= REQ_NUMBER; k++) begin
            idx = (int'(last) + k) % REQ_NUMBER;
            if (!found && valid[idx]) begin
                win   = ID_WIDTH'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_any_valid = |req_valid;
    assign w_accept_en = (r_state == EMPTY) || out_ready;
    // Gated by rst so no requester sees an accept while reset is held.
    assign w_accept    = rst && w_accept_en && w_any_valid;
    assign w_winner    = rr_winner(req_valid, r_last_grant);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    request_mux #(
        .REQ_NUMBER (REQ_NUMBER),
        .REQ_WIDTH  (REQ_WIDTH)
    ) u_request_mux (
        .data     (req_data),
        .select   (w_winner),
        .selected (w_mux_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= EMPTY;
            r_out_data   <= '0;
            r_out_id     <= '0;
            r_last_grant <= ID_WIDTH'(REQ_NUMBER - 1);
        end else if (w_accept) begin
            r_state      <= FULL;
            r_out_data   <= w_mux_data;
            r_out_id     <= w_winner;
            r_last_grant <= w_winner;
        end else if ((r_state == FULL) && out_ready) begin
            r_state      <= EMPTY;
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

`default_nettype wire

// File: tb/tb_request_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_request_arbiter
// Brief   : Self-checking bench for request_arbiter with a behavioural model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_request_arbiter;

    localparam int N = 8;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [W-1:0]  req_data [N];
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [2:0]    out_id;
    logic          out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state: what the output register must hold.
    bit           m_full = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_id   = 0;
    int           m_last = N - 1;
    logic [W-1:0] sb [$];

    request_arbiter #(
        .REQ_NUMBER (N),
        .REQ_WIDTH  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, plus an acceptance scoreboard.
    always @(negedge clk) begin
        int           win;
        int           idx;
        logic [N-1:0] exp_rdy;
        if (!rst) begin
            m_full = 1'b0;
            m_data = '0;
            m_id   = 0;
            m_last = N - 1;
            sb.delete();
        end
        win     = -1;
        exp_rdy = '0;
        if (rst && (!m_full || out_ready)) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (win < 0 && req_valid[idx]) win = idx;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;

        check("m_out_valid", 64'(out_valid), 64'(m_full));
        check("m_out_data",  64'(out_data),  64'(m_data));
        check("m_out_id",    64'(out_id),    64'(m_id));
        check("m_req_ready", 64'(req_ready), 64'(exp_rdy));
        check("onehot",      64'($countones(req_ready) <= 1), 64'(1));

        if (rst && out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) check("sb_data", 64'(out_data), 64'(sb.pop_front()));
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) sb.push_back(req_data[i]);
            end
            if (win >= 0) begin
                m_full = 1'b1;
                m_data = req_data[win];
                m_id   = win;
                m_last = win;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i] = W'(i * 1000);

        // Reset state, with requests already pending.
        @(posedge clk); #1 req_valid = '1; out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_out_id",    64'(out_id),    64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));

        // Full rotation 0..7,0 after release.
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("first_ready", 64'(req_ready), 64'h01);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("rot_valid", 64'(out_valid), 64'(1));
            check("rot_id",    64'(out_id),    64'(k % 8));
            check("rot_data",  64'(out_data),  64'((k % 8) * 1000));
        end

        // Sole requester 5 for four cycles.
        @(posedge clk); #1 req_valid = 8'h20;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            if (k == 3) #1 req_valid = '0;
            @(negedge clk);
            check("sole_id",   64'(out_id),   64'(5));
            check("sole_data", 64'(out_data), 64'(5000));
        end
        @(negedge clk);
        check("drain_valid", 64'(out_valid), 64'(0));

        // Backpressure: output frozen for 5 cycles.
        @(posedge clk); #1 req_valid = '1; out_ready = 1'b0;
        @(negedge clk);
        check("bp_accept", 64'(req_ready), 64'h40);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_id",    64'(out_id),    64'(6));
            check("bp_data",  64'(out_data),  64'(6000));
            check("bp_ready", 64'(req_ready), 64'(0));
            check("bp_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready", 64'(req_ready), 64'h80);
        @(negedge clk);
        check("bp_rel_id", 64'(out_id), 64'(7));

        // Wrap-around: last grant 6, requesters 7 and 1.
        @(posedge clk); #1 req_valid = 8'h40;
        @(negedge clk);
        check("wrap_pre_id",    64'(out_id),    64'(0));
        check("wrap_pre_ready", 64'(req_ready), 64'h40);
        @(posedge clk); #1 req_valid = 8'h82;
        @(negedge clk);
        check("wrap_id6",    64'(out_id),    64'(6));
        check("wrap_ready7", 64'(req_ready), 64'h80);
        @(negedge clk);
        check("wrap_id7",    64'(out_id),    64'(7));
        check("wrap_ready1", 64'(req_ready), 64'h02);
        @(negedge clk);
        check("wrap_id1",   64'(out_id),   64'(1));
        check("wrap_data1", 64'(out_data), 64'(1000));

        // Reset while FULL drops the output at once.
        @(posedge clk); #1 req_valid = '1;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        check("mid_rst_id",    64'(out_id),    64'(0));
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'h01);
        @(negedge clk);
        check("post_rst_id",    64'(out_id),    64'(0));
        check("post_rst_valid", 64'(out_valid), 64'(1));

        // Random traffic, checked by the model and scoreboard.
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom);
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) req_data[i] = $urandom;
        end
        @(posedge clk); #1 req_valid = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
